// File: rtl/div_if.sv
// ----------------------------------------------------------------------------
// div_if
//   Handshake and data bundle between the control unit and the divider.
//
//   Signals:
//     CtoD     control -> divider  start request (level, sampled in IDLE)
//     A, B     control -> divider  dividend / divisor, two's complement
//     DtoC     divider -> control  done strobe, one cycle wide
//     DivZero  divider -> control  divide-by-zero flag, coincident with DtoC
//     busy     divider -> control  operation in progress
//     Hi, Lo   divider -> control  remainder / quotient of last division
//
//   Modports:
//     master  control side (drives the request and operands)
//     slave   divider side (drives the status and results)
// ----------------------------------------------------------------------------
interface div_if #(
    parameter int WIDTH = 32
);
    logic             CtoD;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             DtoC;
    logic             DivZero;
    logic             busy;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output CtoD, A, B,
        input  DtoC, DivZero, busy, Hi, Lo
    );

    modport slave (
        input  CtoD, A, B,
        output DtoC, DivZero, busy, Hi, Lo
    );
endinterface

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
//   Multicycle signed divider with MIPS DIV semantics. A restoring
//   shift/subtract loop on operand magnitudes produces one quotient bit per
//   clock; signs are reapplied when the result is written to Hi/Lo.
//   Quotient truncates toward zero, remainder takes the dividend's sign.
//
//   Ports:
//     clock  system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    div_if.slave
//              CtoD    in   start request (sampled only in IDLE)
//              A, B    in   dividend / divisor, latched on the accepting edge
//              DtoC    out  done strobe, one cycle
//              DivZero out  divide-by-zero flag, coincident with DtoC
//              busy    out  high in CALC and DONE
//              Hi      out  remainder of last completed nonzero division
//              Lo      out  quotient of last completed nonzero division
//
//   WIDTH must be even and >= 4.
// ----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic  clock,
    input  logic  reset,
    div_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] q_reg;       // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] r_reg;       // partial remainder
    logic [WIDTH-1:0] b_mag_reg;   // divisor magnitude
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [CW-1:0]    count_reg;
    logic             sign_a_reg;  // remainder sign = dividend sign
    logic             sign_q_reg;  // quotient sign = sign(A) xor sign(B)
    logic             dtoc_reg;
    logic             divzero_reg;

    // Operand magnitudes. Negating the most negative value yields the same
    // bit pattern, which read as unsigned is exactly 2^(WIDTH-1).
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_mag = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
    assign b_mag = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;

    // One restoring step. The shifted remainder is kept WIDTH+1 bits wide so
    // the borrow out of the trial subtraction is an exact "R' < |B|" test.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_diff;
    logic             r_ge;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    assign r_shift = {r_reg, q_reg[WIDTH-1]};
    assign r_diff  = r_shift - {1'b0, b_mag_reg};
    assign r_ge    = ~r_diff[WIDTH];
    assign r_next  = r_ge ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    assign q_next  = {q_reg[WIDTH-2:0], r_ge};

    // Sign correction applied to the final step's results.
    logic [WIDTH-1:0] lo_final;
    logic [WIDTH-1:0] hi_final;

    assign lo_final = sign_q_reg ? (~q_next + 1'b1) : q_next;
    assign hi_final = sign_a_reg ? (~r_next + 1'b1) : r_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            q_reg       <= '0;
            r_reg       <= '0;
            b_mag_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            count_reg   <= '0;
            sign_a_reg  <= 1'b0;
            sign_q_reg  <= 1'b0;
            dtoc_reg    <= 1'b0;
            divzero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    dtoc_reg    <= 1'b0;
                    divzero_reg <= 1'b0;
                    if (bus.CtoD) begin
                        if (bus.B == '0) begin
                            // Zero divisor: report immediately, results untouched.
                            state_reg   <= DONE;
                            dtoc_reg    <= 1'b1;
                            divzero_reg <= 1'b1;
                        end else begin
                            state_reg  <= CALC;
                            sign_a_reg <= bus.A[WIDTH-1];
                            sign_q_reg <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                            q_reg      <= a_mag;
                            b_mag_reg  <= b_mag;
                            r_reg      <= '0;
                            count_reg  <= CW'(WIDTH - 1);
                        end
                    end
                end

                CALC: begin
                    q_reg     <= q_next;
                    r_reg     <= r_next;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == '0) begin
                        // Last step: publish the signed results together with
                        // the done strobe so they are valid in the DONE cycle.
                        state_reg <= DONE;
                        lo_reg    <= lo_final;
                        hi_reg    <= hi_final;
                        dtoc_reg  <= 1'b1;
                    end
                end

                DONE: begin
                    state_reg   <= IDLE;
                    dtoc_reg    <= 1'b0;
                    divzero_reg <= 1'b0;
                end

                default: begin
                    state_reg   <= IDLE;
                    dtoc_reg    <= 1'b0;
                    divzero_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DtoC    = dtoc_reg;
    assign bus.DivZero = divzero_reg;
    assign bus.busy    = (state_reg != IDLE);
    assign bus.Hi      = hi_reg;
    assign bus.Lo      = lo_reg;

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
//   Directed bench for div_unit (WIDTH=32). Expected results come from a
//   behavioural signed-division model and are queued when an operation is
//   started; each DtoC pops and compares one entry.
// ----------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
    } res_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           ref_cyc = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    res_t         sb[$];

    div_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Model: divide magnitudes, reapply signs; a zero divisor keeps Hi/Lo.
    task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t         e;
        logic [W-1:0] ma, mb, q, r;
        if (b == '0) begin
            e.lo = exp_lo;
            e.hi = exp_hi;
            e.dz = 1'b1;
        end else begin
            ma = a[W-1] ? -a : a;
            mb = b[W-1] ? -b : b;
            q  = ma / mb;
            r  = ma % mb;
            e.lo = (a[W-1] ^ b[W-1]) ? -q : q;
            e.hi = a[W-1] ? -r : r;
            e.dz = 1'b0;
            exp_lo = e.lo;
            exp_hi = e.hi;
        end
        sb.push_back(e);
    endtask

    // Drive a request and return just after the accepting edge E0.
    task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        push_op(a, b);
        @(negedge clock);
        bus.CtoD = 1'b1;
        bus.A    = a;
        bus.B    = b;
        @(posedge clock);
        #1;
        ref_cyc = cyc;
        check({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
    endtask

    // Wait (bounded) for DtoC, check latency from ref_cyc, compare against the
    // scoreboard, then check the strobe lasts one cycle.
    task automatic wait_done(input string tag, input int lat);
        int   n;
        res_t e;
        n = 0;
        while (bus.DtoC !== 1'b1 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_dtoc_seen"}, 32'(bus.DtoC), 32'd1);
        check({tag, "_latency"}, 32'(cyc - ref_cyc), 32'(lat));
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_lo"}, bus.Lo, e.lo);
            check({tag, "_hi"}, bus.Hi, e.hi);
            check({tag, "_divzero"}, 32'(bus.DivZero), 32'(e.dz));
        end
        $display("op %s: Lo=0x%h Hi=0x%h DivZero=%b latency=%0d", tag, bus.Lo, bus.Hi,
                 bus.DivZero, cyc - ref_cyc);
        ref_cyc = cyc;
        @(posedge clock);
        #1;
        check({tag, "_dtoc_one_cycle"}, 32'(bus.DtoC), 32'd0);
        check({tag, "_divzero_one_cycle"}, 32'(bus.DivZero), 32'd0);
        check({tag, "_busy_back_idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run_pulse(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(tag, a, b);
        bus.CtoD = 1'b0;
        wait_done(tag, (b == '0) ? 0 : W);
    endtask

    initial begin
        int extra;
        bus.CtoD = 1'b0;
        bus.A    = '0;
        bus.B    = '0;

        // Reset state
        #1;
        check("rst_dtoc", 32'(bus.DtoC), 32'd0);
        check("rst_divzero", 32'(bus.DivZero), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.Hi, 32'd0);
        check("rst_lo", bus.Lo, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Basic and sign combinations
        run_pulse("7/2", 32'd7, 32'd2);
        run_pulse("-7/2", -32'sd7, 32'd2);
        run_pulse("7/-2", 32'd7, -32'sd2);
        run_pulse("-7/-2", -32'sd7, -32'sd2);

        // Divide by zero keeps the preloaded results
        run_pulse("20/3", 32'd20, 32'd3);
        run_pulse("5/0", 32'd5, 32'd0);

        // Boundaries
        run_pulse("min/-1", 32'h8000_0000, 32'hFFFF_FFFF);
        run_pulse("0/5", 32'd0, 32'd5);
        run_pulse("-1/1", 32'hFFFF_FFFF, 32'd1);
        run_pulse("min/7", 32'h8000_0000, 32'd7);
        run_pulse("max/-3", 32'h7FFF_FFFF, -32'sd3);

        // Request and operand activity during CALC is ignored
        start_op("100/7_noise", 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            bus.CtoD = ~bus.CtoD;
            bus.A    = $urandom;
            bus.B    = $urandom;
        end
        @(negedge clock);
        bus.CtoD = 1'b0;
        wait_done("100/7_noise", W);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.DtoC === 1'b1) extra++;
        end
        check("noise_extra_dtoc", 32'(extra), 32'd0);

        // Asynchronous reset mid-operation: outputs clear at once, no DtoC
        @(negedge clock);
        bus.CtoD = 1'b1;
        bus.A    = 32'd50;
        bus.B    = 32'd3;
        @(posedge clock);
        #1;
        bus.CtoD = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check("abort_dtoc", 32'(bus.DtoC), 32'd0);
        check("abort_divzero", 32'(bus.DivZero), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.Hi, 32'd0);
        check("abort_lo", bus.Lo, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.DtoC === 1'b1 || bus.busy === 1'b1) extra++;
        end
        check("abort_no_dtoc", 32'(extra), 32'd0);

        // CtoD held high: back-to-back operations. The gap between done
        // strobes is 34 edges (32 steps, DONE->IDLE, IDLE accept, accept
        // edge), i.e. 35 cycles counting both done cycles.
        push_op(32'd9, 32'd3);
        push_op(32'd9, 32'd3);
        push_op(32'd9, 32'd3);
        @(negedge clock);
        bus.CtoD = 1'b1;
        bus.A    = 32'd9;
        bus.B    = 32'd3;
        @(posedge clock);
        #1;
        ref_cyc = cyc;
        wait_done("b2b_0", W);
        wait_done("b2b_1", W + 2);
        wait_done("b2b_2", W + 2);
        bus.CtoD = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("b2b_idle_after_drop", 32'(bus.busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
